frame_pixel_writer: RTL and testbench

//  Downstream of the frame-capture FSM: arms on its FRAME_REQ pulse, waits for the imager

---
 rtl/frame_pixel_writer_if.sv | 13 +
 rtl/frame_pixel_writer.sv | 146 ++++++++++++++
 tb/tb_frame_pixel_writer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pixel_writer_if.sv
// Imager read-out and host pipe FIFO signals for frame_pixel_writer.
// master drives the imager side and fifo_full; slave is the writer.
interface frame_pixel_writer_if #(parameter int PIX_W = 10);
  logic             fval;
  logic             dval;
  logic [PIX_W-1:0] pix_data;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [31:0]      fifo_din;

  modport master (output fval, dval, pix_data, fifo_full, input fifo_wr_en, fifo_din);
  modport slave  (input fval, dval, pix_data, fifo_full, output fifo_wr_en, fifo_din);
endinterface

// File: rtl/frame_pixel_writer.sv
// Arms on frame_req, captures one imager frame, packs 4 bytes per word into the pipe FIFO.
// Optional FRAME_PIXEL_WRITER_TESTPAT_EN replaces pixel data with a pix_count ramp.
module frame_pixel_writer #(
  parameter int          PIX_W        = 10,
  parameter int          FRAME_PIXELS = 315392,
  parameter int          CNT_W        = 20,
  parameter logic [23:0] TIMEOUT_CYC  = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_req,
  frame_pixel_writer_if.slave  bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     pix_count,
  output logic                 overflow,
  output logic                 short_frame,
  output logic                 timeout
);
  // state   | meaning
  // IDLE    | waiting for frame_req
  // ARMED   | waiting for fval rise, wait counter running
  // CAPTURE | accepting pixels
  // DONE    | one-cycle frame_done
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIXELS);

  state_t           state, state_next;
  logic             fval_s1, dval_s1, fval_prev;
  logic [23:0]      wait_cnt;
  logic [31:0]      pack, pack_next;
  logic [7:0]       pix_byte;
  logic [CNT_W-1:0] cnt_next;
  logic             arm, accept, word_done, flush, set_short, set_timeout;
  logic             rise, fall;

`ifdef FRAME_PIXEL_WRITER_TESTPAT_EN
  assign pix_byte = pix_count[7:0];
`else
  logic [7:0] pix_s1;
  assign pix_byte = pix_s1;
  always_ff @(posedge clk) begin
    if (rst) pix_s1 <= '0;
    else     pix_s1 <= bus.pix_data[PIX_W-1 -: 8];
  end
`endif

  assign rise       = fval_s1 & ~fval_prev;
  assign fall       = ~fval_s1 & fval_prev;
  assign busy       = (state == ARMED) || (state == CAPTURE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    arm         = 1'b0;
    accept      = 1'b0;
    word_done   = 1'b0;
    flush       = 1'b0;
    set_short   = 1'b0;
    set_timeout = 1'b0;
    cnt_next    = pix_count;
    pack_next   = pack;
    case (state)
      IDLE: begin
        if (frame_req) begin
          state_next = ARMED;
          arm        = 1'b1;
        end
      end
      ARMED: begin
        if (rise) begin
          state_next = CAPTURE;
        end else if (wait_cnt == 24'd0) begin
          state_next  = IDLE;
          set_timeout = 1'b1;
        end
      end
      CAPTURE: begin
        accept = dval_s1 && (pix_count < LAST);
        if (accept) begin
          cnt_next = pix_count + 1'b1;
          pack_next[{pix_count[1:0], 3'b000} +: 8] = pix_byte;
          word_done = (pix_count[1:0] == 2'd3);
        end
        // a pixel landing on the fval fall still counts toward completion
        if (cnt_next == LAST) begin
          state_next = DONE;
        end else if (fall) begin
          state_next = DONE;
          set_short  = 1'b1;
          flush      = (cnt_next[1:0] != 2'd0);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fval_s1        <= 1'b0;
      dval_s1        <= 1'b0;
      fval_prev      <= 1'b0;
      wait_cnt       <= '0;
      pack           <= '0;
      pix_count      <= '0;
      overflow       <= 1'b0;
      short_frame    <= 1'b0;
      timeout        <= 1'b0;
      bus.fifo_wr_en <= 1'b0;
      bus.fifo_din   <= '0;
    end else begin
      fval_s1        <= bus.fval;
      dval_s1        <= bus.dval;
      fval_prev      <= fval_s1;
      bus.fifo_wr_en <= 1'b0;
      if (arm) begin
        wait_cnt    <= TIMEOUT_CYC - 24'd1;
        pack        <= '0;
        pix_count   <= '0;
        overflow    <= 1'b0;
        short_frame <= 1'b0;
        timeout     <= 1'b0;
      end
      if (state == ARMED && wait_cnt != 24'd0) wait_cnt <= wait_cnt - 24'd1;
      if (accept) pix_count <= cnt_next;
      // unused lanes are already zero because pack clears after every word
      if (word_done || flush) begin
        pack         <= '0;
        bus.fifo_din <= pack_next;
        if (bus.fifo_full) overflow <= 1'b1;
        else               bus.fifo_wr_en <= 1'b1;
      end else if (accept) begin
        pack <= pack_next;
      end
      if (set_short)   short_frame <= 1'b1;
      if (set_timeout) timeout     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_pixel_writer.sv
// Randomised frame traces checked cycle by cycle against a trace-scanning reference model.
module tb_frame_pixel_writer;
  localparam int          PIX_W = 10;
  localparam int          FP    = 16;
  localparam int          CNT_W = 20;
  localparam logic [23:0] TO    = 24'd100;
  localparam int          TOI   = 100;
  localparam int          MAXL  = 200;
  localparam int          A     = 3;

`ifdef FRAME_PIXEL_WRITER_TESTPAT_EN
  localparam logic [31:0] LIT_W0 = 32'h03020100;
  localparam logic [31:0] LIT_W3 = 32'h0F0E0D0C;
  localparam logic [31:0] LIT_S1 = 32'h00000504;
`else
  localparam logic [31:0] LIT_W0 = 32'h04030201;
  localparam logic [31:0] LIT_W3 = 32'h100F0E0D;
  localparam logic [31:0] LIT_S1 = 32'h00000605;
`endif

  logic clk = 1'b0, rst = 1'b1, frame_req = 1'b0;
  logic busy, frame_done, overflow, short_frame, timeout;
  logic [CNT_W-1:0] pix_count;

  frame_pixel_writer_if #(.PIX_W(PIX_W)) bus();

  frame_pixel_writer #(.PIX_W(PIX_W), .FRAME_PIXELS(FP), .CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .bus(bus),
    .busy(busy), .frame_done(frame_done), .pix_count(pix_count),
    .overflow(overflow), .short_frame(short_frame), .timeout(timeout));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cur_k = 0;

  // stimulus trace: index k is what the DUT samples at the k-th edge of this trace
  bit tf[MAXL], td[MAXL], tff[MAXL], treq[MAXL], trst[MAXL];
  logic [PIX_W-1:0] tp[MAXL];
  int L;

  // expected outputs after edge k
  bit ew[MAXL], edone[MAXL], ebusy[MAXL], eovf[MAXL], esh[MAXL], eto[MAXL];
  logic [31:0] edin[MAXL];
  int ecnt[MAXL];
  int prev_cnt = 0;
  bit prev_ovf = 0, prev_sh = 0, prev_to = 0;

  int nwr, ndone;
  logic [31:0] din_seen[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cur_k, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int idx, input int n);
`ifdef FRAME_PIXEL_WRITER_TESTPAT_EN
    logic [31:0] nv;
    nv = n;
    return nv[7:0];
`else
    logic [PIX_W-1:0] pv;
    pv = tp[idx];
    return pv[PIX_W-1 -: 8];
`endif
  endfunction

  task automatic clear_trace();
    for (int k = 0; k < MAXL; k++) begin
      tf[k] = 0; td[k] = 0; tff[k] = 0; treq[k] = 0; trst[k] = 0; tp[k] = '0;
    end
  endtask

  // Scan the trace by the frame rules: find the arming rise, walk accepted pixels,
  // emit words and flag events, then fold events into per-cycle expectations.
  task automatic build_model();
    int cnt_ev[MAXL];
    bit ovf_ev[MAXL], sh_ev[MAXL], to_ev[MAXL];
    int r, e, cnt, rc;
    bit ro, rs, rt, dead;
    logic [31:0] word;
    for (int k = 0; k < MAXL; k++) begin
      cnt_ev[k] = -1; ovf_ev[k] = 0; sh_ev[k] = 0; to_ev[k] = 0;
      ew[k] = 0; edone[k] = 0; ebusy[k] = 0; edin[k] = '0;
    end
    r = -1;
    for (int i = A; i < A + TOI && i < L; i++)
      if (tf[i] && !tf[i-1]) begin r = i; break; end
    if (r < 0) begin
      for (int k = A; k < A + TOI; k++) ebusy[k] = 1;
      to_ev[A + TOI] = 1;
    end else begin
      cnt = 0; word = '0; e = L - 3;
      for (int j = r + 1; j < L - 2; j++) begin
        if (td[j] && cnt < FP) begin
          word[8*(cnt%4) +: 8] = byte_of(j, cnt);
          cnt++;
          cnt_ev[j+1] = cnt;
          if (cnt % 4 == 0) begin
            if (tff[j+1]) ovf_ev[j+1] = 1;
            else begin ew[j+1] = 1; edin[j+1] = word; end
            word = '0;
          end
        end
        if (cnt == FP || (!tf[j] && tf[j-1])) begin
          if (cnt != FP) begin
            sh_ev[j+1] = 1;
            if (cnt % 4 != 0) begin
              if (tff[j+1]) ovf_ev[j+1] = 1;
              else begin ew[j+1] = 1; edin[j+1] = word; end
            end
          end
          edone[j+1] = 1;
          e = j;
          break;
        end
      end
      for (int k = A; k <= e; k++) ebusy[k] = 1;
    end
    rc = prev_cnt; ro = prev_ovf; rs = prev_sh; rt = prev_to; dead = 0;
    for (int k = 0; k < L; k++) begin
      if (k == A) begin rc = 0; ro = 0; rs = 0; rt = 0; end
      if (cnt_ev[k] >= 0) rc = cnt_ev[k];
      if (ovf_ev[k]) ro = 1;
      if (sh_ev[k]) rs = 1;
      if (to_ev[k]) rt = 1;
      if (trst[k]) dead = 1;
      if (dead) begin
        rc = 0; ro = 0; rs = 0; rt = 0;
        ew[k] = 0; edone[k] = 0; ebusy[k] = 0;
      end
      ecnt[k] = rc; eovf[k] = ro; esh[k] = rs; eto[k] = rt;
    end
    prev_cnt = rc; prev_ovf = ro; prev_sh = rs; prev_to = rt;
  endtask

  task automatic gen(input int npix, input bit dvof, input int gap, input int dv_pct,
                     input int ff_pct, input int rst_pix, input bit det);
    int i, n, r, fi, m;
    clear_trace();
    for (int k = 0; k < A; k++) begin
      td[k] = 1'($urandom_range(0, 1)); tp[k] = PIX_W'($urandom);
    end
    treq[A] = 1;
    r = det ? A + 2 : A + 1 + $urandom_range(0, 3);
    treq[r+1] = 1;  // arrives while ARMED, must be ignored
    tf[r] = 1; td[r] = !det; tp[r] = PIX_W'($urandom);
    i = r + 1; n = 0; m = -1;
    while (n < npix) begin
      tf[i] = 1;
      if (det || $urandom_range(0, 99) < dv_pct) begin
        td[i] = 1;
        tp[i] = det ? {8'(n + 1), 2'b10} : PIX_W'($urandom);
        n++;
        if (n == rst_pix) m = i + 1;
      end
      i++;
    end
    fi = i + gap;
    for (int k = i; k < fi; k++) tf[k] = 1;
    if (dvof) begin td[fi] = 1; tp[fi] = PIX_W'($urandom); end
    L = fi + 8;
    for (int k = 0; k < L; k++) tff[k] = ($urandom_range(0, 99) < ff_pct);
    if (m >= 0) begin
      trst[m] = 1;
      for (int k = m; k < MAXL; k++) begin tf[k] = 0; td[k] = 0; end
      L = m + 6;
    end
  endtask

  task automatic gen_timeout(input bit pre_high);
    clear_trace();
    treq[A] = 1;
    L = A + TOI + 10;
    if (pre_high)
      for (int k = 1; k <= A + TOI + 2; k++) begin
        tf[k] = 1; td[k] = 1'($urandom_range(0, 1));
      end
  endtask

  task automatic run_trace();
    build_model();
    nwr = 0; ndone = 0;
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      rst = trst[k]; frame_req = treq[k];
      bus.fval = tf[k]; bus.dval = td[k]; bus.pix_data = tp[k]; bus.fifo_full = tff[k];
      @(posedge clk);
      #2;
      cur_k = k;
      check("busy", busy, ebusy[k]);
      check("frame_done", frame_done, edone[k]);
      check("fifo_wr_en", bus.fifo_wr_en, ew[k]);
      if (ew[k]) check("fifo_din", bus.fifo_din, edin[k]);
      check("pix_count", 32'(pix_count), 32'(ecnt[k]));
      check("overflow", overflow, eovf[k]);
      check("short_frame", short_frame, esh[k]);
      check("timeout", timeout, eto[k]);
      if (bus.fifo_wr_en === 1'b1) begin
        if (nwr < 8) din_seen[nwr] = bus.fifo_din;
        nwr++;
      end
      if (frame_done === 1'b1) ndone++;
    end
  endtask

  initial begin
    int kind;
    bus.fval = 0; bus.dval = 0; bus.pix_data = '0; bus.fifo_full = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_wr_en", bus.fifo_wr_en, 0);
    check("rst_din", bus.fifo_din, 0);
    check("rst_count", 32'(pix_count), 0);
    check("rst_flags", {overflow, short_frame, timeout}, 0);
    @(negedge clk);
    rst = 0;

    // full frame with known pixels
    gen(16, 0, 3, 100, 0, 0, 1);
    run_trace();
    check("full_writes", nwr, 4);
    check("full_done", ndone, 1);
    check("full_word0", din_seen[0], LIT_W0);
    check("full_word3", din_seen[3], LIT_W3);
    check("full_count", 32'(pix_count), 16);

    // early fall after 6 pixels: flush with upper lanes zero
    gen(6, 0, 2, 100, 0, 0, 1);
    run_trace();
    check("short_writes", nwr, 2);
    check("short_word1", din_seen[1], LIT_S1);
    check("short_flag", short_frame, 1);

    // fifo_full on the third word's write cycle
    gen(16, 0, 3, 100, 0, 0, 1);
    tff[A + 2 + 13] = 1;
    run_trace();
    check("ovf_writes", nwr, 3);
    check("ovf_flag", overflow, 1);
    check("ovf_word_after", din_seen[2], LIT_W3);

    // timeout with fval low
    gen_timeout(0);
    run_trace();
    check("to_done", ndone, 0);
    check("to_writes", nwr, 0);
    check("to_flag", timeout, 1);
    check("to_busy", busy, 0);

    // reset mid-capture, then a re-arm
    gen(16, 0, 3, 100, 0, 6, 0);
    run_trace();
    check("rst_mid_writes", nwr, 1);
    check("rst_mid_count", 32'(pix_count), 0);

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: gen(16 + $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 70,
               ($urandom_range(0, 1) != 0) ? 25 : 0, 0, 0);
        1: gen($urandom_range(1, 14), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 70, 20, 0, 0);
        2: gen(15, 1, 0, 70, 0, 0, 0);
        3: gen_timeout(1'($urandom_range(0, 1)));
        4: gen(16, 0, 2, 70, 20, $urandom_range(1, 15), 0);
        default: gen(16, 0, 2, 60, 40, 0, 0);
      endcase
      run_trace();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
